// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO with valid/ready
// handshakes on both sides.
// Features:
//   - programmable almost-full and almost-empty thresholds
//   - sticky overflow and underflow error flags
//   - a synchronous flush
// Optional feature: define SYNC_FIFO_PEAK_EN to build peak-occupancy
// tracking. When it is undefined, peak_count is tied to zero.
// Full and empty are decoded from the occupancy counter, never from a
// pointer compare.
module sync_fifo_fwft #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr,
  output logic [$clog2(DEPTH):0]     peak_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Status decodes depend only on the count register, so they can change
  // only after a clock edge.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == {CW{1'b0}});

  // A flush discards any transfer in the same cycle, and that discarded
  // transfer must not be reported as an error either.
  assign w_wr_fire = wr_valid & ~w_full  & ~flush;
  assign w_rd_fire = rd_ready & ~w_empty & ~flush;
  assign w_ovf_evt = wr_valid & w_full   & ~flush;
  assign w_udf_evt = rd_ready & w_empty  & ~flush;

  assign wr_ready     = ~w_full;
  assign rd_valid     = ~w_empty;
  assign rd_data      = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
  assign count        = r_count;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Storage array: written on an accepted write, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Write pointer: advances modulo DEPTH on each accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {AW{1'b0}};
    end else if (w_wr_fire) begin
      r_wr_ptr <= r_wr_ptr + P_ONE;
    end
  end

  // Read pointer: advances modulo DEPTH on each accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= {AW{1'b0}};
    end else if (flush) begin
      r_rd_ptr <= {AW{1'b0}};
    end else if (w_rd_fire) begin
      r_rd_ptr <= r_rd_ptr + P_ONE;
    end
  end

  // Occupancy counter: +1 on write only, -1 on read only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (flush) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag: a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      r_overflow <= 1'b1;
    end else if (err_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Sticky underflow flag: a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (w_udf_evt) begin
      r_underflow <= 1'b1;
    end else if (err_clr) begin
      r_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_PEAK_EN
  logic [CW-1:0] r_peak;

  // Peak tracker: registers max(peak, count), so it lags count by one cycle.
  // It survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak <= {CW{1'b0}};
    end else if (err_clr) begin
      r_peak <= {CW{1'b0}};
    end else if (r_count > r_peak) begin
      r_peak <= r_count;
    end
  end

  assign peak_count = r_peak;
`else
  assign peak_count = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed self-checking bench for sync_fifo_fwft (WIDTH=8, DEPTH=8,
// AF_THRESH=6, AE_THRESH=1). Expected peak_count values follow
// SYNC_FIFO_PEAK_EN.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       reset, flush, wr_valid, rd_ready, err_clr;
  logic [7:0] wr_data;
  logic       wr_ready, rd_valid, almost_full, almost_empty, overflow, underflow;
  logic [7:0] rd_data;
  logic [3:0] count, peak_count;

  int n_tests = 0;
  int n_fail  = 0;
  int peak_en;

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr),
    .peak_count(peak_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef SYNC_FIFO_PEAK_EN
    peak_en = 1;
`else
    peak_en = 0;
`endif
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    err_clr = 1'b0; wr_data = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_peak", 32'(peak_count), 32'd0);

    // Fill with 0x11..0x88 back to back.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 8'((i + 1) * 17);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 6));
      chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 1));
      chk("fill_wr_ready", 32'(wr_ready), 32'((i + 1) < 8));
      chk("fill_head", 32'(rd_data), 32'h11);
    end
    wr_valid = 1'b0;

    // Drain all eight, checking order.
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(rd_data), 32'((i + 1) * 17));
      rd_ready = 1'b1;
      tick();
      chk("drain_count", 32'(count), 32'(7 - i));
      chk("drain_ae", 32'(almost_empty), 32'((7 - i) <= 1));
      chk("drain_rd_valid", 32'(rd_valid), 32'((7 - i) > 0));
    end
    rd_ready = 1'b0;
    chk("drain_rd_data0", 32'(rd_data), 32'd0);
    chk("drain_udf", 32'(underflow), 32'd0);

    // Single-word fall-through with no rd_ready.
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    chk("fwft_valid", 32'(rd_valid), 32'd1);
    chk("fwft_data", 32'(rd_data), 32'hA5);
    tick();
    chk("fwft_hold", 32'(rd_data), 32'hA5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("fwft_count0", 32'(count), 32'd0);
    chk("fwft_data0", 32'(rd_data), 32'd0);

    // Fill with 0x20..0x27, then stream 20 cycles with both sides active.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 8'(32 + i);
      tick();
    end
    chk("stream_full", 32'(count), 32'd8);
    rd_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      // The write presented while full is refused, so 0x28 is offered twice.
      wr_data = (j == 0) ? 8'h28 : 8'(40 + j - 1);
      chk("stream_data", 32'(rd_data), 32'(32 + j));
      tick();
      chk("stream_count", 32'(count), 32'd7);
    end
    wr_valid = 1'b0;
    chk("stream_ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 7; k++) begin
      chk("stream_tail", 32'(rd_data), 32'(52 + k));
      tick();
    end
    rd_ready = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);
    chk("stream_ovf_sticky", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Underflow and clear priority.
    rd_ready = 1'b1;
    tick();
    chk("udf_set", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    tick();
    chk("udf_err_wins", 32'(underflow), 32'd1);
    rd_ready = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("udf_cleared", 32'(underflow), 32'd0);

    // Flush with a concurrent write, then flush with a read on empty.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(80 + i);
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    rd_ready = 1'b1;
    tick();
    flush = 1'b0; rd_ready = 1'b0;
    chk("flush_no_udf", 32'(underflow), 32'd0);
    wr_valid = 1'b1; wr_data = 8'h3C;
    tick();
    wr_valid = 1'b0;
    chk("post_flush_data", 32'(rd_data), 32'h3C);
    chk("post_flush_count", 32'(count), 32'd1);

    // Reset mid-operation discards contents.
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    reset = 1'b1; wr_data = 8'hDD;
    tick();
    reset = 1'b0; wr_valid = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_peak", 32'(peak_count), 32'd0);
    wr_valid = 1'b1; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    chk("midrst_first", 32'(rd_data), 32'h77);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("peak_clr0", 32'(peak_count), 32'd0);

    // Peak tracking: write 7, read 4, write 2.
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    chk("peak_lag", 32'(peak_count), (peak_en != 0) ? 32'd6 : 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("peak_rd_data", 32'(rd_data), 32'(i + 1));
      tick();
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 8);
      tick();
    end
    wr_valid = 1'b0;
    chk("peak_count5", 32'(count), 32'd5);
    chk("peak_7", 32'(peak_count), (peak_en != 0) ? 32'd7 : 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("peak_after_flush", 32'(peak_count), (peak_en != 0) ? 32'd7 : 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk("peak_after_clr", 32'(peak_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It extends the team's basic counter-based FIFO with:
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- a synchronous flush
- optional peak-occupancy tracking

It sits between producer and consumer stages inside the ALU datapath wherever rate decoupling is needed, and it uses its own internal register array.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of entries; power of two, ≥2
- `AF_THRESH`, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- `AE_THRESH`, 1, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  synchronous discard of all stored entries
- `wr_valid`  in  1  producer presents `wr_data`
- `wr_data`  in  WIDTH  write word
- `wr_ready`  out  1  FIFO can accept a word; equals !full
- `rd_valid`  out  1  `rd_data` holds the oldest word; equals !empty
- `rd_data`  out  WIDTH  oldest stored word; 0 when rd_valid=0
- `rd_ready`  in  1  consumer accepts `rd_data`
- `count`  out  $clog2(DEPTH)+1  number of stored entries
- `almost_full`  out  1  count ≥ AF_THRESH
- `almost_empty`  out  1  count ≤ AE_THRESH
- `overflow`  out  1  sticky: a write was attempted while full
- `underflow`  out  1  sticky: a read was attempted while empty
- `err_clr`  in  1  clears overflow, underflow and peak_count
- `peak_count`  out  $clog2(DEPTH)+1  maximum count observed (see Configuration)

## Operation
- Write transfer: wr_valid & wr_ready at an edge. Data is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read transfer: rd_valid & rd_ready at an edge. rd_ptr increments modulo DEPTH.
- rd_data is a combinational read of mem[rd_ptr], gated to 0 when empty. This gives first-word-fall-through: no read command latency.
- count update:
  - +1 on write only
  - −1 on read only
  - unchanged on both or neither
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from count, never from pointer compare.
- Simultaneous read and write:
  - When 0<count<DEPTH: both complete and count is unchanged.
  - When empty: the write completes; no read occurs (rd_valid=0).
  - When full: the read completes; the write is refused (wr_ready=0) and raises overflow.
- overflow is set at the edge where wr_valid & !wr_ready. underflow is set at the edge where rd_ready & !rd_valid.
- err_clr clears overflow, underflow and peak_count. A new error in the same cycle wins: the flag ends the cycle at 1.
- flush zeroes wr_ptr, rd_ptr and count. Any write or read in the same cycle is discarded and does not raise an error flag. The error flags are untouched by flush.
- reset has priority over flush. It clears pointers, count, flags and peak_count. Memory contents are not reset.
- Reset mid-operation discards all contents. The first write after reset deasserts lands at entry 0.

## Timing
- Reset values:
  - wr_ready=1, rd_valid=0, rd_data=0, count=0
  - almost_full=0, almost_empty=1
  - overflow=0, underflow=0, peak_count=0
- Write-to-read latency is 1 cycle: a word written at edge N gives rd_valid=1 with that word on rd_data after edge N.
- wr_ready, rd_valid, almost_full and almost_empty are combinational decodes of the count register. They change only after a clock edge and never depend combinationally on wr_valid or rd_ready.
- A refilled slot is reusable on the cycle after the read edge that freed it.

## Configuration
- `SYNC_FIFO_PEAK_EN` defined: peak_count is updated each edge to max(peak_count, count), so it lags count by one cycle. It is cleared by reset or err_clr, but not by flush.
- Not defined: peak_count is tied to 0 and no tracking logic is built. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- Reset, then write 0x11..0x88 on 8 back-to-back cycles → count=8, wr_ready=0, almost_full=1 from count=6. Then read 8 → data 0x11..0x88 in order, rd_valid=0, almost_empty=1 at count ≤1.
- Write 0xA5 once → rd_valid=1 and rd_data=0xA5 on the next cycle with no rd_ready asserted. Assert rd_ready → count=0, rd_data=0.
- Fill to 8, then hold wr_valid=1, rd_ready=1 for 20 cycles → 20 reads in order, one write per freed slot, overflow=1, pointers wrap twice with no data loss.
- Empty FIFO, pulse rd_ready → underflow=1. Pulse err_clr with rd_ready still high → underflow stays 1. Pulse err_clr alone → underflow=0.
- Write 5 words, then assert flush with wr_valid=1 → count=0, rd_valid=0, overflow=0. The next write of 0x3C reads back as 0x3C.
- With SYNC_FIFO_PEAK_EN: write 7, read 4, write 2 → peak_count=7. Flush → still 7. err_clr → 0. Without the macro → peak_count=0 throughout.
